// File: rtl/alu_display_pkg.sv
// Shared types for the ALU result display: digit codes, segment glyphs and controller states.
package alu_display_pkg;

    typedef logic [4:0] digit_t;

    localparam digit_t DIG_BLANK = 5'd16;
    localparam digit_t DIG_H     = 5'd17;
    localparam digit_t DIG_D     = 5'd18;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Active-low segment pattern {g,f,e,d,c,b,a} for a digit code.
    function automatic logic [6:0] glyph(input digit_t d);
        logic [6:0] s;
        case (d)
            5'd0:    s = 7'h40;
            5'd1:    s = 7'h79;
            5'd2:    s = 7'h24;
            5'd3:    s = 7'h30;
            5'd4:    s = 7'h19;
            5'd5:    s = 7'h12;
            5'd6:    s = 7'h02;
            5'd7:    s = 7'h78;
            5'd8:    s = 7'h00;
            5'd9:    s = 7'h10;
            5'd10:   s = 7'h08;
            5'd11:   s = 7'h03;
            5'd12:   s = 7'h46;
            5'd13:   s = 7'h21;
            5'd14:   s = 7'h06;
            5'd15:   s = 7'h0E;
            DIG_H:   s = 7'h09;
            DIG_D:   s = 7'h21;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_display_bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, one bit per clock.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] bcd_o
);

    logic [19:0] sr_q;
    logic [19:0] adj;
    logic [2:0]  iter_q;
    logic        busy_q;

    always_comb begin
        adj = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (adj[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            sr_q   <= {12'd0, bin_i};
            iter_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            sr_q   <= {adj[18:0], 1'b0};
            iter_q <= iter_q + 3'd1;
            if (iter_q == 3'd7) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (iter_q == 3'd7);
    assign bcd_o  = sr_q[19:8];

endmodule

// File: rtl/alu_display.sv
// Four-digit multiplexed 7-segment display of the ALU result bus, decimal or hex,
// with the mode glyph on the leftmost digit.
module alu_display
    import alu_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       hex_mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t state_q, state_d;

    logic [7:0]  cap_value_q;
    logic        cap_mode_q;
    logic [7:0]  shown_value_q;
    logic        shown_mode_q;
    logic        shown_valid_q;
    digit_t      dig_q [4];

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [6:0]       seg_q;
    logic [3:0]       an_q;
    logic             busy_q, busy_d;

    logic        start;
    logic        commit;
    logic        conv_busy;
    logic        conv_done;
    logic [11:0] conv_bcd;

    assign start = (state_q == ST_IDLE) &&
                   (!shown_valid_q || (value != shown_value_q) || (hex_mode != shown_mode_q));

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start && !hex_mode),
        .bin_i   (value),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = hex_mode ? ST_DONE : ST_SHIFT;
            // Leaving on !conv_busy too keeps a desynchronised converter from hanging SHIFT.
            ST_SHIFT: if (conv_done || !conv_busy) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != ST_IDLE);
        commit = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_value_q   <= '0;
            cap_mode_q    <= 1'b0;
            shown_value_q <= '0;
            shown_mode_q  <= 1'b0;
            shown_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= DIG_BLANK;
            end
        end else begin
            busy_q <= busy_d;
            if (start) begin
                cap_value_q <= value;
                cap_mode_q  <= hex_mode;
            end
            if (commit) begin
                shown_value_q <= cap_value_q;
                shown_mode_q  <= cap_mode_q;
                shown_valid_q <= 1'b1;
                if (cap_mode_q) begin
                    dig_q[0] <= {1'b0, cap_value_q[3:0]};
                    dig_q[1] <= {1'b0, cap_value_q[7:4]};
                    dig_q[2] <= DIG_BLANK;
                    dig_q[3] <= DIG_H;
                end else begin
                    dig_q[0] <= {1'b0, conv_bcd[3:0]};
                    dig_q[1] <= (conv_bcd[11:4] == 8'd0) ? DIG_BLANK : {1'b0, conv_bcd[7:4]};
                    dig_q[2] <= (conv_bcd[11:8] == 4'd0) ? DIG_BLANK : {1'b0, conv_bcd[11:8]};
                    dig_q[3] <= DIG_D;
                end
            end
        end
    end

    // Scan runs freely; segment and anode registers follow the index one cycle later, together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= 4'hF;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            seg_q <= glyph(dig_q[idx_q]);
            an_q  <= ~(4'b0001 << idx_q);
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_alu_display.sv
// Self-checking bench for alu_display: directed scenarios plus random values against an arithmetic model.
module tb_alu_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value = 8'd0;
    logic       hex_mode = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Codes 0-15 hex digits, 16 blank, 17 'H', 18 'd'.
    int glyph_tab [19] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                           'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E,
                           'h7F, 'h09, 'h21};
    int exp_d [4];
    int cur_v = -1;
    int cur_m = -1;

    alu_display #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .hex_mode (hex_mode),
        .seg      (seg),
        .an       (an),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void set_model(input int v, input int m);
        if (m != 0) begin
            exp_d[0] = v % 16;
            exp_d[1] = v / 16;
            exp_d[2] = 16;
            exp_d[3] = 17;
        end else begin
            exp_d[0] = v % 10;
            exp_d[1] = (v >= 10) ? (v / 10) % 10 : 16;
            exp_d[2] = (v >= 100) ? v / 100 : 16;
            exp_d[3] = 18;
        end
    endfunction

    function automatic int an_index(input logic [3:0] a);
        case (a)
            4'hE:    return 0;
            4'hD:    return 1;
            4'hB:    return 2;
            4'h7:    return 3;
            default: return -1;
        endcase
    endfunction

    task automatic apply(input int v, input int m);
        value    = 8'(v);
        hex_mode = m[0];
        set_model(v, m);
        cur_v = v;
        cur_m = m;
    endtask

    // Count busy cycles following the current negedge until busy falls (bounded).
    task automatic wait_conv(input int exp_cnt, input string tag);
        int cnt = 0;
        int first = -1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                cnt++;
                if (first < 0) first = t;
            end else if (cnt > 0) begin
                break;
            end
        end
        chk({tag, " busy_cycles"}, cnt, exp_cnt);
        if (exp_cnt > 0) chk({tag, " busy_start"}, first, 1);
    endtask

    task automatic sample_seg(input string tag);
        int idx;
        idx = an_index(an);
        if (idx < 0) chk({tag, " an_onehot"}, an, 4'hE);
        else chk({tag, " seg"}, seg, glyph_tab[exp_d[idx]]);
    endtask

    task automatic check_display(input string tag);
        int seen [4] = '{0, 0, 0, 0};
        int idx;
        @(negedge clk);
        for (int t = 0; t < 4 * DIV; t++) begin
            @(negedge clk);
            idx = an_index(an);
            if (idx >= 0) seen[idx]++;
            sample_seg(tag);
        end
        for (int i = 0; i < 4; i++) chk({tag, " digit_dwell"}, seen[i], DIV);
    endtask

    initial begin
        int cnt;
        int v;
        int m;
        int exp_cnt;

        apply(173, 0);
        #12;
        chk("reset seg", seg, 7'h7F);
        chk("reset an", an, 4'hF);
        chk("reset busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_conv(9, "dec173");
        check_display("dec173");

        apply(5, 0);   wait_conv(9, "dec5");   check_display("dec5");
        apply(0, 0);   wait_conv(9, "dec0");   check_display("dec0");
        apply(200, 0); wait_conv(9, "dec200"); check_display("dec200");

        apply(8'hAF, 1); wait_conv(1, "hexAF"); check_display("hexAF");

        // Value changes while converting 99; 255 must follow after one idle cycle.
        apply(99, 0);
        cnt = 0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
        end
        value = 8'd255;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
            else if (cnt > 0) break;
        end
        chk("midchg first_busy", cnt, 9);
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (t == 1) chk("midchg restart", busy, 1'b1);
            if (t == 10) chk("midchg second_end", busy, 1'b0);
            sample_seg("midchg commit99");
        end
        set_model(255, 0);
        cur_v = 255;
        check_display("midchg 255");

        // Reset in the middle of a conversion.
        apply(123, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst seg", seg, 7'h7F);
        chk("midrst an", an, 4'hF);
        chk("midrst busy", busy, 1'b0);
        apply(42, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_conv(9, "postrst");
        check_display("postrst");

        apply(16, 0); wait_conv(9, "mode16 dec"); check_display("mode16 dec");
        apply(16, 1); wait_conv(1, "mode16 hex"); check_display("mode16 hex");

        for (int n = 0; n < 14; n++) begin
            v = int'($urandom_range(0, 255));
            m = int'($urandom_range(0, 1));
            if (n == 5) begin
                v = cur_v;
                m = cur_m;
            end
            exp_cnt = (v != cur_v || m != cur_m) ? ((m != 0) ? 1 : 9) : 0;
            apply(v, m);
            wait_conv(exp_cnt, "rand");
            check_display("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
